// File: rtl/taxi_fare_pkg.sv
// Shared taxi-meter definitions.
//   ST_*           : fare-timer FSM state encoding (2 bits, 3 is illegal)
//   *_MIN_DEF      : default minute constants, also used by the distance-fare block
package taxi_fare_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRACE = 2'd1;
    localparam logic [1:0] ST_BILL  = 2'd2;

    localparam int WAIT_MIN_DEF  = 10;
    localparam int GRACE_MIN_DEF = 0;

endpackage

// File: rtl/min_down_ctr.sv
// Loadable minute down-counter.
//   clk, rst  : clock, async active-high reset (cnt -> RST_VAL)
//   load      : load load_val (wins over en)
//   load_val  : reload value
//   en        : decrement by one
//   cnt       : current count
//   term      : cnt == 1, i.e. the next enabled minute completes the interval
module min_down_ctr #(
    parameter int CNT_W   = 8,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             term
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= CNT_W'(RST_VAL);
        else if (load)
            cnt <= load_val;
        else if (en)
            cnt <= cnt - CNT_W'(1);
    end

    assign term = (cnt == CNT_W'(1));

endmodule

// File: rtl/wait_fare_timer.sv
// Waiting-time fare timer. Counts minute strobes while the vehicle waits
// during an active trip; after an optional free grace period, emits one fare
// event per WAIT_MIN billed minutes.
//   clk, rst        : clock, async active-high reset
//   min_tick        : 1-cycle per-minute strobe
//   waiting         : vehicle stopped / below billing speed
//   trip_active     : meter engaged
//   trip_start      : clear totals and begin a new trip (highest priority)
//   fare_evt        : fare event, strobe (TOGGLE_OUT=0) or toggle (TOGGLE_OUT=1)
//   wait_units      : fare events this trip, saturating
//   wait_min_total  : waiting minutes this trip (grace + billed), saturating
//   in_grace        : registered state==GRACE
//   state           : FSM state for debug
module wait_fare_timer
    import taxi_fare_pkg::*;
#(
    parameter int WAIT_MIN   = WAIT_MIN_DEF,
    parameter int GRACE_MIN  = GRACE_MIN_DEF,
    parameter int CNT_W      = 8,
    parameter int UNIT_W     = 8,
    parameter int TOGGLE_OUT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              min_tick,
    input  logic              waiting,
    input  logic              trip_active,
    input  logic              trip_start,
    output logic              fare_evt,
    output logic [UNIT_W-1:0] wait_units,
    output logic [UNIT_W-1:0] wait_min_total,
    output logic              in_grace,
    output logic [1:0]        state
);

    localparam logic [UNIT_W-1:0] UNIT_MAX = '1;

    logic [1:0]       nxt_state;
    logic             qtick;
    logic             grace_load, grace_en, grace_term;
    logic             period_load, period_en, period_term;
    logic             evt_hit, min_inc;
    logic [CNT_W-1:0] grace_cnt, period_cnt;

    // Counter values are only consumed through their terminal flags; the
    // values themselves stay as named nets for debug probing.
    logic unused_cnt;
    assign unused_cnt = ^{grace_cnt, period_cnt};

    // trip_start swallows a coincident tick so a new trip never starts
    // with a minute already counted.
    assign qtick = min_tick & waiting & trip_active & ~trip_start;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= nxt_state;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        nxt_state = state;
        if (trip_start) begin
            nxt_state = (GRACE_MIN > 0) ? ST_GRACE : ST_BILL;
        end else begin
            case (state)
                ST_IDLE:  nxt_state = ST_IDLE;
                ST_GRACE: begin
                    if (!trip_active)
                        nxt_state = ST_IDLE;
                    else if (qtick && grace_term)
                        nxt_state = ST_BILL;
                end
                ST_BILL:  begin
                    if (!trip_active)
                        nxt_state = ST_IDLE;
                end
                default:  nxt_state = ST_IDLE;   // illegal encoding recovers
            endcase
        end
    end

    // ---------------- FSM: outputs / counter controls ----------------
    always_comb begin
        grace_load  = trip_start;
        grace_en    = 1'b0;
        period_load = trip_start;
        period_en   = 1'b0;
        evt_hit     = 1'b0;
        min_inc     = 1'b0;
        case (state)
            ST_GRACE: begin
                min_inc  = qtick;
                grace_en = qtick & ~grace_term;
            end
            ST_BILL: begin
                min_inc     = qtick;
                period_en   = qtick & ~period_term;
                evt_hit     = qtick & period_term;
                period_load = trip_start | (qtick & period_term);
            end
            default: ;
        endcase
    end

    min_down_ctr #(.CNT_W(CNT_W), .RST_VAL(GRACE_MIN)) u_grace_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (grace_load),
        .load_val (CNT_W'(GRACE_MIN)),
        .en       (grace_en),
        .cnt      (grace_cnt),
        .term     (grace_term)
    );

    min_down_ctr #(.CNT_W(CNT_W), .RST_VAL(WAIT_MIN)) u_period_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (period_load),
        .load_val (CNT_W'(WAIT_MIN)),
        .en       (period_en),
        .cnt      (period_cnt),
        .term     (period_term)
    );

    // ---------------- registered outputs ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fare_evt       <= 1'b0;
            wait_units     <= '0;
            wait_min_total <= '0;
            in_grace       <= 1'b0;
        end else begin
            if (TOGGLE_OUT != 0)
                fare_evt <= fare_evt ^ evt_hit;
            else
                fare_evt <= evt_hit;

            if (trip_start) begin
                wait_units     <= '0;
                wait_min_total <= '0;
            end else begin
                if (evt_hit && wait_units != UNIT_MAX)
                    wait_units <= wait_units + UNIT_W'(1);
                if (min_inc && wait_min_total != UNIT_MAX)
                    wait_min_total <= wait_min_total + UNIT_W'(1);
            end

            in_grace <= (nxt_state == ST_GRACE);
        end
    end

endmodule

// File: tb/tb_wait_fare_timer.sv
// Bench for wait_fare_timer: four differently parameterised instances share
// one stimulus bus; each scenario checks the instance it targets.
module tb_wait_fare_timer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic min_tick = 1'b0, waiting = 1'b0, trip_active = 1'b0, trip_start = 1'b0;

    always #5 clk = ~clk;

    // A: WAIT=10 GRACE=0   B: WAIT=5 GRACE=3   C: WAIT=2 toggle   D: WAIT=1 UNIT_W=2
    logic       a_evt, b_evt, c_evt, d_evt;
    logic [7:0] a_units, a_total, b_units, b_total, c_units, c_total;
    logic [1:0] d_units, d_total;
    logic       a_ing, b_ing, c_ing, d_ing;
    logic [1:0] a_st, b_st, c_st, d_st;

    wait_fare_timer #(.WAIT_MIN(10), .GRACE_MIN(0)) u_a (
        .clk(clk), .rst(rst), .min_tick(min_tick), .waiting(waiting),
        .trip_active(trip_active), .trip_start(trip_start), .fare_evt(a_evt),
        .wait_units(a_units), .wait_min_total(a_total), .in_grace(a_ing), .state(a_st));
    wait_fare_timer #(.WAIT_MIN(5), .GRACE_MIN(3)) u_b (
        .clk(clk), .rst(rst), .min_tick(min_tick), .waiting(waiting),
        .trip_active(trip_active), .trip_start(trip_start), .fare_evt(b_evt),
        .wait_units(b_units), .wait_min_total(b_total), .in_grace(b_ing), .state(b_st));
    wait_fare_timer #(.WAIT_MIN(2), .GRACE_MIN(0), .TOGGLE_OUT(1)) u_c (
        .clk(clk), .rst(rst), .min_tick(min_tick), .waiting(waiting),
        .trip_active(trip_active), .trip_start(trip_start), .fare_evt(c_evt),
        .wait_units(c_units), .wait_min_total(c_total), .in_grace(c_ing), .state(c_st));
    wait_fare_timer #(.WAIT_MIN(1), .GRACE_MIN(0), .UNIT_W(2)) u_d (
        .clk(clk), .rst(rst), .min_tick(min_tick), .waiting(waiting),
        .trip_active(trip_active), .trip_start(trip_start), .fare_evt(d_evt),
        .wait_units(d_units), .wait_min_total(d_total), .in_grace(d_ing), .state(d_st));

    typedef struct {
        logic       evt;
        logic       ing;
        logic [7:0] units;
        logic [7:0] total;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int checks = 0;
    int errors = 0;

    // All drives happen just after a negedge; one call spans one posedge and
    // returns at the next negedge, where outputs are sampled.
    task automatic cycle(input logic tick);
        min_tick = tick;
        @(negedge clk);
        min_tick = 1'b0;
    endtask

    task automatic start_trip();
        trip_start  = 1'b1;
        trip_active = 1'b1;
        @(negedge clk);
        trip_start  = 1'b0;
    endtask

    task automatic push(input logic evt, input logic ing, input int units, input int total);
        exp_t x;
        x.evt = evt; x.ing = ing; x.units = 8'(units); x.total = 8'(total);
        sbq.push_back(x);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({a_evt, a_units, a_total, a_ing, a_st} !== 19'd0) begin
            errors++;
            $display("FAIL reset_a got evt=%b units=%0d total=%0d ing=%b st=%0d want all 0",
                     a_evt, a_units, a_total, a_ing, a_st);
        end
        checks++;
        if ({b_evt, b_ing, b_st, c_evt, d_evt, d_units, d_total} !== 10'd0) begin
            errors++;
            $display("FAIL reset_bcd got b_evt=%b b_ing=%b b_st=%0d c_evt=%b d_evt=%b d_units=%0d want 0",
                     b_evt, b_ing, b_st, c_evt, d_evt, d_units);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // 25 waiting ticks with varying spacing: strobes after ticks 10 and 20.
    task automatic test_basic_billing();
        start_trip();
        waiting = 1'b1;
        checks++;
        if (a_st !== 2'd2) begin
            errors++; $display("FAIL basic_state got %0d want 2", a_st);
        end
        for (int i = 1; i <= 25; i++) begin
            push(i % 10 == 0, 1'b0, i / 10, i);
            cycle(1'b1);
            e = sbq.pop_front();
            checks++;
            if ({a_evt, a_ing, a_units, a_total} !== {e.evt, e.ing, e.units, e.total}) begin
                errors++;
                $display("FAIL basic_tick%0d got evt=%b units=%0d total=%0d want evt=%b units=%0d total=%0d",
                         i, a_evt, a_units, a_total, e.evt, e.units, e.total);
            end
            for (int g = 0; g < i % 3; g++) begin
                cycle(1'b0);
                checks++;
                if (a_evt !== 1'b0) begin
                    errors++; $display("FAIL basic_strobe_width tick%0d got %b want 0", i, a_evt);
                end
            end
        end
    endtask

    // GRACE=3 WAIT=5: grace covers ticks 1-3, events after ticks 8 and 13.
    task automatic test_grace();
        start_trip();
        waiting = 1'b1;
        checks++;
        if ({b_ing, b_st} !== 3'b1_01) begin
            errors++; $display("FAIL grace_entry got ing=%b st=%0d want ing=1 st=1", b_ing, b_st);
        end
        for (int i = 1; i <= 13; i++) begin
            push((i > 3) && ((i - 3) % 5 == 0), i < 3, (i > 3) ? (i - 3) / 5 : 0, i);
            cycle(1'b1);
            e = sbq.pop_front();
            checks++;
            if ({b_evt, b_ing, b_units, b_total} !== {e.evt, e.ing, e.units, e.total}) begin
                errors++;
                $display("FAIL grace_tick%0d got evt=%b ing=%b units=%0d total=%0d want evt=%b ing=%b units=%0d total=%0d",
                         i, b_evt, b_ing, b_units, b_total, e.evt, e.ing, e.units, e.total);
            end
        end
    endtask

    // 6 waiting, 4 moving (ignored), 4 waiting: single event on the 10th waiting tick.
    task automatic test_pause();
        int wt;
        start_trip();
        wt = 0;
        for (int i = 1; i <= 14; i++) begin
            waiting = (i <= 6 || i > 10);
            if (waiting) wt++;
            push(waiting && wt == 10, 1'b0, (wt == 10) ? 1 : 0, wt);
            cycle(1'b1);
            e = sbq.pop_front();
            checks++;
            if ({a_evt, a_units, a_total} !== {e.evt, e.units, e.total}) begin
                errors++;
                $display("FAIL pause_tick%0d got evt=%b units=%0d total=%0d want evt=%b units=%0d total=%0d",
                         i, a_evt, a_units, a_total, e.evt, e.units, e.total);
            end
        end
    endtask

    // trip_start on the completing tick wins; period restarts from WAIT_MIN.
    task automatic test_start_priority();
        start_trip();
        waiting = 1'b1;
        repeat (9) cycle(1'b1);
        trip_start = 1'b1;
        min_tick   = 1'b1;
        @(negedge clk);
        trip_start = 1'b0;
        min_tick   = 1'b0;
        checks++;
        if ({a_evt, a_units, a_total, a_st} !== {1'b0, 8'd0, 8'd0, 2'd2}) begin
            errors++;
            $display("FAIL start_prio got evt=%b units=%0d total=%0d st=%0d want 0 0 0 2",
                     a_evt, a_units, a_total, a_st);
        end
        for (int i = 1; i <= 10; i++) begin
            push(i == 10, 1'b0, (i == 10) ? 1 : 0, i);
            cycle(1'b1);
            e = sbq.pop_front();
            checks++;
            if ({a_evt, a_units, a_total} !== {e.evt, e.units, e.total}) begin
                errors++;
                $display("FAIL start_prio_reload tick%0d got evt=%b units=%0d total=%0d want evt=%b units=%0d total=%0d",
                         i, a_evt, a_units, a_total, e.evt, e.units, e.total);
            end
        end
    endtask

    // Toggle output, then trip end holds everything.
    task automatic test_toggle_and_idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start_trip();
        waiting = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            push((i / 2) % 2 == 1, 1'b0, i / 2, i);
            cycle(1'b1);
            e = sbq.pop_front();
            checks++;
            if ({c_evt, c_units, c_total} !== {e.evt, e.units, e.total}) begin
                errors++;
                $display("FAIL toggle_tick%0d got evt=%b units=%0d total=%0d want evt=%b units=%0d total=%0d",
                         i, c_evt, c_units, c_total, e.evt, e.units, e.total);
            end
        end
        trip_active = 1'b0;
        cycle(1'b0);
        repeat (4) cycle(1'b1);
        checks++;
        if ({c_evt, c_units, c_total, c_st} !== {1'b1, 8'd3, 8'd6, 2'd0}) begin
            errors++;
            $display("FAIL idle_hold got evt=%b units=%0d total=%0d st=%0d want 1 3 6 0",
                     c_evt, c_units, c_total, c_st);
        end
    endtask

    // WAIT=1, UNIT_W=2: every tick fires, counts stick at 3; async reset mid-stream.
    task automatic test_saturation_and_reset();
        int fires;
        start_trip();
        waiting = 1'b1;
        fires = 0;
        for (int i = 1; i <= 6; i++) begin
            push(1'b1, 1'b0, (i > 3) ? 3 : i, (i > 3) ? 3 : i);
            cycle(1'b1);
            e = sbq.pop_front();
            if (d_evt === 1'b1) fires++;
            checks++;
            if ({d_evt, 6'd0, d_units, 6'd0, d_total} !== {e.evt, e.units, e.total}) begin
                errors++;
                $display("FAIL sat_tick%0d got evt=%b units=%0d total=%0d want evt=%b units=%0d total=%0d",
                         i, d_evt, d_units, d_total, e.evt, e.units, e.total);
            end
            cycle(1'b0);
        end
        checks++;
        if (fires != 6) begin
            errors++; $display("FAIL sat_fire_count got %0d want 6", fires);
        end
        min_tick = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({d_evt, d_units, d_total, d_ing, d_st, a_units, a_total, a_st} !== 24'd0) begin
            errors++;
            $display("FAIL async_reset got d_evt=%b d_units=%0d d_total=%0d d_st=%0d a_total=%0d a_st=%0d want 0",
                     d_evt, d_units, d_total, d_st, a_total, a_st);
        end
        @(negedge clk);
        min_tick = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({d_evt, d_units, d_st} !== 5'd0) begin
            errors++;
            $display("FAIL reset_no_pending got evt=%b units=%0d st=%0d want 0", d_evt, d_units, d_st);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_billing();
        test_grace();
        test_pause();
        test_start_priority();
        test_toggle_and_idle();
        test_saturation_and_reset();
        checks++;
        if (sbq.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain got %0d left want 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
